// File: rtl/bit_restore.sv
// ---------------------------------------------------------------------------
// bit_restore
//
// Registered inverse bit permuter. The forward reorderer on the far side of
// the link produces out[i] = in[pos[i]]; this block undoes it with
// m_data[pos[i]] = s_data[i], using the currently active map.
//
// The map is loaded entry by entry into a shadow table. A commit walks the
// shadow table once, one entry per cycle, and checks that every position is
// used exactly once. Only a valid permutation is copied into the active map,
// so a bad configuration can never corrupt the data path.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   cfg_wr/cfg_idx/cfg_pos    shadow table write port
//   cfg_commit                start validation of the shadow table
//   cfg_busy                  validation in progress
//   cfg_ok / cfg_err          one-cycle result pulses
//   s_valid/s_ready/s_data    scrambled input stream
//   m_valid/m_ready/m_data    restored output stream (one register stage)
//
// State  | meaning
// -------+-----------------------------------------------------------------
// RUN    | streaming with the active map; shadow table writable
// CHECK  | walking shadow[0..DATA_WIDTH-1]; input stalled, output may drain
// ---------------------------------------------------------------------------
module bit_restore #(
    parameter int DATA_WIDTH = 32,
    parameter int IDX_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  cfg_wr,
    input  logic [IDX_WIDTH-1:0]  cfg_idx,
    input  logic [IDX_WIDTH-1:0]  cfg_pos,
    input  logic                  cfg_commit,
    output logic                  cfg_busy,
    output logic                  cfg_ok,
    output logic                  cfg_err,

    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,

    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_CHECK = 1'b1
    } state_t;

    localparam logic [IDX_WIDTH-1:0] K_LAST = IDX_WIDTH'(DATA_WIDTH - 1);

    state_t                 state_q, state_d;

    logic [IDX_WIDTH-1:0]   shadow_q [DATA_WIDTH];
    logic [IDX_WIDTH-1:0]   shadow_d [DATA_WIDTH];
    logic [IDX_WIDTH-1:0]   active_q [DATA_WIDTH];
    logic [IDX_WIDTH-1:0]   active_d [DATA_WIDTH];

    logic [DATA_WIDTH-1:0]  seen_q, seen_d;
    logic                   dup_q, dup_d;
    logic [IDX_WIDTH-1:0]   k_q, k_d;

    logic                   m_valid_q, m_valid_d;
    logic [DATA_WIDTH-1:0]  m_data_q, m_data_d;
    logic                   cfg_ok_q, cfg_ok_d;
    logic                   cfg_err_q, cfg_err_d;

    logic                   k_last;
    logic [IDX_WIDTH-1:0]   check_pos;
    logic                   dup_final;
    logic                   accept;
    logic [DATA_WIDTH-1:0]  restored;

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (cfg_commit) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (k_last) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        cfg_busy = (state_q == ST_CHECK);
        // Input is frozen for the whole check so no word can straddle the
        // map switch; the output register keeps draining independently.
        s_ready  = (state_q == ST_RUN) && (!m_valid_q || m_ready);
    end

    // ------------------------------------------------------------------
    // Data path and check engine
    // ------------------------------------------------------------------
    assign k_last    = (k_q == K_LAST);
    assign check_pos = shadow_q[k_q];
    // The last entry's duplicate status is folded in combinationally so the
    // verdict is ready on the same edge that leaves CHECK.
    assign dup_final = dup_q | seen_q[check_pos];
    assign accept    = s_valid && s_ready;

    always_comb begin
        restored = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            restored[active_q[i]] = s_data[i];
        end
    end

    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        seen_d    = seen_q;
        dup_d     = dup_q;
        k_d       = k_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        cfg_ok_d  = 1'b0;
        cfg_err_d = 1'b0;

        if (state_q == ST_RUN) begin
            // A write in the commit cycle still lands, so the check that
            // follows sees it.
            if (cfg_wr) begin
                shadow_d[cfg_idx] = cfg_pos;
            end
            seen_d = '0;
            dup_d  = 1'b0;
            k_d    = '0;
        end else begin
            seen_d[check_pos] = 1'b1;
            dup_d             = dup_final;
            k_d               = k_q + IDX_WIDTH'(1);
            if (k_last) begin
                seen_d = '0;
                dup_d  = 1'b0;
                k_d    = '0;
                if (dup_final) begin
                    cfg_err_d = 1'b1;
                end else begin
                    cfg_ok_d = 1'b1;
                    active_d = shadow_q;
                end
            end
        end

        if (accept) begin
            m_data_d  = restored;
            m_valid_d = 1'b1;
        end else if (m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register and all other flops
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RUN;
            for (int i = 0; i < DATA_WIDTH; i++) begin
                shadow_q[i] <= IDX_WIDTH'(i);
                active_q[i] <= IDX_WIDTH'(i);
            end
            seen_q    <= '0;
            dup_q     <= 1'b0;
            k_q       <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            cfg_ok_q  <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            seen_q    <= seen_d;
            dup_q     <= dup_d;
            k_q       <= k_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            cfg_ok_q  <= cfg_ok_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign cfg_ok  = cfg_ok_q;
    assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_bit_restore.sv
// ---------------------------------------------------------------------------
// tb_bit_restore
//
// Bench for bit_restore. Fixed vectors with hand-derived results are applied
// from a table; every accepted input word is also pushed onto a scoreboard
// (restored with a reference copy of the map) and popped when it leaves the
// output. Hand sequences cover backpressure, commit with a held word and
// reset in the middle of a check.
// ---------------------------------------------------------------------------
module tb_bit_restore;

    localparam int DW = 32;
    localparam int IW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_wr;
    logic [IW-1:0] cfg_idx;
    logic [IW-1:0] cfg_pos;
    logic          cfg_commit;
    logic          cfg_busy;
    logic          cfg_ok;
    logic          cfg_err;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;

    always #5 clk = ~clk;

    bit_restore #(.DATA_WIDTH(DW), .IDX_WIDTH(IW)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_wr     (cfg_wr),
        .cfg_idx    (cfg_idx),
        .cfg_pos    (cfg_pos),
        .cfg_commit (cfg_commit),
        .cfg_busy   (cfg_busy),
        .cfg_ok     (cfg_ok),
        .cfg_err    (cfg_err),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data)
    );

    typedef struct {
        logic [DW-1:0] din;
        logic [DW-1:0] dexp;
    } vec_t;

    vec_t          vecs [7];
    int            total = 0;
    int            bad   = 0;

    logic [IW-1:0] shadow_m [DW];
    logic [IW-1:0] active_m [DW];
    logic [IW-1:0] map_w    [DW];
    logic [DW-1:0] sb [$];

    logic          have_prev  = 1'b0;
    logic          prev_valid = 1'b0;
    logic          prev_ready = 1'b0;
    logic [DW-1:0] prev_data  = '0;

    task automatic chk(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] restore_m(input logic [DW-1:0] d);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < DW; i++) r[active_m[i]] = d[i];
        return r;
    endfunction

    // Scoreboard / reference model, evaluated mid-cycle.
    always @(negedge clk) begin
        logic [DW-1:0] e;
        if (rst) begin
            sb.delete();
            for (int i = 0; i < DW; i++) begin
                shadow_m[i] = IW'(i);
                active_m[i] = IW'(i);
            end
            have_prev = 1'b0;
        end else begin
            if (cfg_ok) begin
                for (int i = 0; i < DW; i++) active_m[i] = shadow_m[i];
            end
            if (have_prev && prev_valid && !prev_ready) begin
                chk("hold_valid", 32'(m_valid), 32'd1);
                chk("hold_data", m_data, prev_data);
            end
            if (m_valid && m_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    chk("sb_data", m_data, e);
                end
            end
            if (s_valid && s_ready) sb.push_back(restore_m(s_data));
            if (cfg_wr && !cfg_busy) shadow_m[cfg_idx] = cfg_pos;
            have_prev  = 1'b1;
            prev_valid = m_valid;
            prev_ready = m_ready;
            prev_data  = m_data;
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout: got running, want finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_vec(input vec_t v, input string name);
        m_ready = 1'b1;
        s_valid = 1'b1;
        s_data  = v.din;
        @(negedge clk);
        chk({name, "_s_ready"}, 32'(s_ready), 32'd1);
        tick();
        s_valid = 1'b0;
        @(negedge clk);
        chk({name, "_m_valid"}, 32'(m_valid), 32'd1);
        chk({name, "_m_data"}, m_data, v.dexp);
        tick();
    endtask

    task automatic write_map();
        for (int i = 0; i < DW; i++) begin
            cfg_wr  = 1'b1;
            cfg_idx = IW'(i);
            cfg_pos = map_w[i];
            tick();
        end
        cfg_wr = 1'b0;
    endtask

    task automatic commit_wait(input bit expect_ok, input string name);
        int bc;
        bit got;
        bc  = 0;
        got = 1'b0;
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (cfg_ok || cfg_err) begin
                got = 1'b1;
                break;
            end
            if (cfg_busy) bc++;
        end
        chk({name, "_pulse_seen"}, 32'(got), 32'd1);
        chk({name, "_busy_cycles"}, 32'(bc), 32'd32);
        chk({name, "_ok"}, 32'(cfg_ok), 32'(expect_ok));
        chk({name, "_err"}, 32'(cfg_err), 32'(!expect_ok));
        chk({name, "_busy_at_pulse"}, 32'(cfg_busy), 32'd0);
        tick();
        chk({name, "_pulse_width"}, 32'(cfg_ok | cfg_err), 32'd0);
    endtask

    initial begin
        int            bc;
        int            idx;
        int            acc;
        int            pulses;
        bit            got;
        logic [DW-1:0] words [3];

        vecs[0] = '{din: 32'hDEADBEEF, dexp: 32'hDEADBEEF};  // identity
        vecs[1] = '{din: 32'h12345678, dexp: 32'h12345678};  // identity
        vecs[2] = '{din: 32'h00000008, dexp: 32'h00000008};  // after rejected map
        vecs[3] = '{din: 32'h00000001, dexp: 32'h80000000};  // reversal
        vecs[4] = '{din: 32'h0000F00F, dexp: 32'hF00F0000};  // reversal
        vecs[5] = '{din: 32'hFFFF0003, dexp: 32'hC000FFFF};  // reversal
        vecs[6] = '{din: 32'h00000001, dexp: 32'h00000001};  // identity after reset

        words[0] = 32'h11111111;
        words[1] = 32'h22220000;
        words[2] = 32'h0000ABCD;

        rst        = 1'b1;
        cfg_wr     = 1'b0;
        cfg_idx    = '0;
        cfg_pos    = '0;
        cfg_commit = 1'b0;
        s_valid    = 1'b0;
        s_data     = '0;
        m_ready    = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", m_data, 32'd0);
        chk("rst_busy", 32'(cfg_busy), 32'd0);
        chk("rst_ok_err", 32'({cfg_ok, cfg_err}), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd1);
        tick();

        // Identity after reset
        for (int i = 0; i < 2; i++) apply_vec(vecs[i], "ident");

        // Rejected map: identity except pos[3]=5
        for (int i = 0; i < DW; i++) map_w[i] = IW'(i);
        map_w[3] = IW'(5);
        write_map();
        commit_wait(1'b0, "bad_map");
        apply_vec(vecs[2], "after_err");

        // Bit reversal
        for (int i = 0; i < DW; i++) map_w[i] = IW'(DW - 1 - i);
        write_map();
        commit_wait(1'b1, "rev_map");
        for (int i = 3; i < 6; i++) apply_vec(vecs[i], "rev");

        // Backpressure: three words offered while m_ready=0
        m_ready = 1'b0;
        idx = 0;
        acc = 0;
        for (int c = 0; c < 5; c++) begin
            s_valid = 1'b1;
            s_data  = words[idx];
            @(negedge clk);
            if (s_valid && s_ready) begin
                idx++;
                acc++;
            end
            tick();
        end
        chk("bp_accepted", 32'(acc), 32'd1);
        m_ready = 1'b1;
        for (int c = 0; c < 10 && idx < 3; c++) begin
            s_valid = 1'b1;
            s_data  = words[idx];
            @(negedge clk);
            chk("bp_no_gap", 32'(m_valid), 32'd1);
            if (s_valid && s_ready) idx++;
            tick();
        end
        s_valid = 1'b0;
        @(negedge clk);
        chk("bp_last_valid", 32'(m_valid), 32'd1);
        chk("bp_last_data", m_data, 32'hB3D50000);  // reverse of 0000ABCD
        tick();
        @(negedge clk);
        chk("bp_drained", 32'(m_valid), 32'd0);
        tick();

        // Commit with a held output word; switch reversal -> identity
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 32'h00000003;
        tick();
        s_data  = 32'h00000001;  // offered throughout, must wait for new map
        for (int i = 0; i < DW; i++) map_w[i] = IW'(i);
        write_map();
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        bc  = 0;
        got = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (cfg_ok || cfg_err) begin
                got = 1'b1;
                break;
            end
            if (cfg_busy) begin
                bc++;
                chk("chk_s_ready", 32'(s_ready), 32'd0);
                if (bc == 5) begin
                    chk("held_word", m_data, 32'hC0000000);
                    @(posedge clk);
                    #1;
                    m_ready = 1'b1;
                end
            end
        end
        chk("pend_pulse_seen", 32'(got), 32'd1);
        chk("pend_busy_cycles", 32'(bc), 32'd32);
        chk("pend_ok", 32'(cfg_ok), 32'd1);
        chk("pend_s_ready", 32'(s_ready), 32'd1);
        tick();
        s_valid = 1'b0;
        @(negedge clk);
        chk("new_map_valid", 32'(m_valid), 32'd1);
        chk("new_map_data", m_data, 32'h00000001);
        tick();

        // Reset in the middle of a check
        for (int i = 0; i < DW; i++) map_w[i] = IW'(DW - 1 - i);
        write_map();
        commit_wait(1'b1, "rev_again");
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 32'h0000000F;
        tick();
        s_valid = 1'b0;
        for (int i = 0; i < DW; i++) map_w[i] = IW'((i + 1) % DW);
        write_map();
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        repeat (10) tick();
        @(negedge clk);
        chk("mid_check_busy", 32'(cfg_busy), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_m_valid", 32'(m_valid), 32'd0);
        chk("mrst_busy", 32'(cfg_busy), 32'd0);
        chk("mrst_s_ready", 32'(s_ready), 32'd1);
        m_ready = 1'b1;
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (cfg_ok || cfg_err) pulses++;
        end
        chk("mrst_no_pulse", 32'(pulses), 32'd0);
        tick();
        apply_vec(vecs[6], "mrst_ident");
        commit_wait(1'b1, "shadow_ident");
        apply_vec(vecs[6], "shadow_ident_data");

        repeat (3) tick();
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
